modulo_controle_rolhas: RTL and testbench

Cork-stock controller for the bottling line. Holds the 7-bit cork count (0..99), grants one cork per sealing request through a req/ack handshake, and requests refill batches from the cork dispenser when stock runs low. After every count change it sequentially re-derives the tens and units BCD digits that feed the display path.

---
 rtl/modulo_controle_rolhas.sv | 193 +++++++++++++++++++
 tb/tb_modulo_controle_rolhas.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/modulo_controle_rolhas.sv
// modulo_controle_rolhas
// Cork-stock controller for the bottling line. Keeps the cork count
// (0..MAX_ROLHAS), grants one cork per sealing request with a one-cycle ACK,
// asks the dispenser for LOTE more corks while stock is below LIMIAR, and
// re-derives the BCD tens/units digits after every count change.
//
// Optional feature: define ROLHAS_WATCHDOG_EN to add a refill watchdog that
// raises a sticky ALARME after REQ_REPOR has been high for TIMEOUT cycles.
// Without the macro ALARME is tied to 0 and TIMEOUT only takes part in the
// elaboration-time parameter check.

module modulo_controle_rolhas #(
  parameter int unsigned MAX_ROLHAS = 99,
  parameter int unsigned LIMIAR     = 5,
  parameter int unsigned LOTE       = 15,
  parameter int unsigned TIMEOUT    = 1000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic       REQ_VEDAR,
  output logic       ACK_VEDAR,
  output logic       REQ_REPOR,
  input  logic       REPOR_OK,
  output logic [6:0] REG_R,
  output logic [3:0] REG_RD,
  output logic [3:0] REG_RU,
  output logic       BCD_VALID,
  output logic       VAZIO,
  output logic       ALARME
);

  // Parameters narrowed once to the widths of the datapath they feed.
  localparam logic [6:0] MAX_C    = 7'(MAX_ROLHAS);
  localparam logic [6:0] LIMIAR_C = 7'(LIMIAR);
  localparam logic [7:0] LOTE_C   = 8'(LOTE);

  // Reject parameter sets the 7-bit datapath and 16-bit watchdog cannot hold.
  if ((MAX_ROLHAS > 32'd99) || (LOTE < 32'd1) || (LOTE > 32'd99) ||
      (LIMIAR > 32'd127) || (TIMEOUT < 32'd1) || (TIMEOUT > 32'd65535)) begin : g_param_erro
    $error("modulo_controle_rolhas: illegal parameter set");
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } estado_t;

  estado_t    estado_r, estado_s;
  logic [6:0] reg_r, reg_s;
  logic [3:0] rd_r, rd_s;
  logic [3:0] ru_r, ru_s;
  logic       valid_r, valid_s;
  logic       ack_r, ack_s;
  logic       repor_r, repor_s;
  logic       pend_r, pend_s;
  logic [6:0] temp_r, temp_s;
  logic [3:0] tens_r, tens_s;
  logic       aceita_s;
  logic [6:0] soma_s;

  // Refill addition done in 8 bits so count+LOTE cannot wrap before clamping.
  function automatic logic [6:0] soma_sat(input logic [6:0] atual);
    logic [7:0] soma;
    soma = {1'b0, atual} + LOTE_C;
    if (soma > {1'b0, MAX_C}) begin
      soma_sat = MAX_C;
    end else begin
      soma_sat = soma[6:0];
    end
  endfunction

  // Next-state, datapath and handshake decisions for the IDLE/CONV machine.
  always_comb begin
    estado_s = estado_r;
    reg_s    = reg_r;
    rd_s     = rd_r;
    ru_s     = ru_r;
    valid_s  = valid_r;
    ack_s    = 1'b0;
    temp_s   = temp_r;
    tens_s   = tens_r;
    soma_s   = soma_sat(reg_r);
    // A dispenser delivery only counts while we are actually asking for one.
    aceita_s = REPOR_OK & repor_r;
    pend_s   = pend_r | aceita_s;
    // Request refill while low, but not while a delivery is being absorbed.
    repor_s  = (reg_r < LIMIAR_C) & ~pend_r & ~REPOR_OK;

    case (estado_r)
      ST_IDLE: begin
        if (pend_r) begin
          // Pending refill wins over any grant.
          reg_s    = soma_s;
          pend_s   = aceita_s;
          valid_s  = 1'b0;
          temp_s   = soma_s;
          tens_s   = 4'd0;
          estado_s = ST_CONV;
        end else if (REQ_VEDAR && START && (reg_r != 7'd0) && !aceita_s) begin
          // A refill accepted this cycle is applied first; the grant waits.
          reg_s    = reg_r - 7'd1;
          ack_s    = 1'b1;
          valid_s  = 1'b0;
          temp_s   = reg_r - 7'd1;
          tens_s   = 4'd0;
          estado_s = ST_CONV;
        end else begin
          estado_s = ST_IDLE;
        end
      end
      ST_CONV: begin
        // Repeated subtraction: one tens step per cycle until units remain.
        if (temp_r >= 7'd10) begin
          temp_s = temp_r - 7'd10;
          tens_s = tens_r + 4'd1;
        end else begin
          rd_s     = tens_r;
          ru_s     = temp_r[3:0];
          valid_s  = 1'b1;
          estado_s = ST_IDLE;
        end
      end
      default: begin
        estado_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset to an empty stock.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      estado_r <= ST_IDLE;
      reg_r    <= 7'd0;
      rd_r     <= 4'd0;
      ru_r     <= 4'd0;
      valid_r  <= 1'b1;
      ack_r    <= 1'b0;
      repor_r  <= 1'b0;
      pend_r   <= 1'b0;
      temp_r   <= 7'd0;
      tens_r   <= 4'd0;
    end else begin
      estado_r <= estado_s;
      reg_r    <= reg_s;
      rd_r     <= rd_s;
      ru_r     <= ru_s;
      valid_r  <= valid_s;
      ack_r    <= ack_s;
      repor_r  <= repor_s;
      pend_r   <= pend_s;
      temp_r   <= temp_s;
      tens_r   <= tens_s;
    end
  end

`ifdef ROLHAS_WATCHDOG_EN
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  logic [15:0] wd_cnt_r;
  logic        alarme_r;

  // Watchdog: count cycles of unanswered refill request; alarm is sticky.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wd_cnt_r <= 16'd0;
      alarme_r <= 1'b0;
    end else if (repor_r) begin
      if (wd_cnt_r != 16'hFFFF) begin
        wd_cnt_r <= wd_cnt_r + 16'd1;
      end
      if (wd_cnt_r >= (TIMEOUT_C - 16'd1)) begin
        alarme_r <= 1'b1;
      end
    end else begin
      wd_cnt_r <= 16'd0;
    end
  end

  assign ALARME = alarme_r;
`else
  assign ALARME = 1'b0;
`endif

  assign REG_R     = reg_r;
  assign REG_RD    = rd_r;
  assign REG_RU    = ru_r;
  assign BCD_VALID = valid_r;
  assign ACK_VEDAR = ack_r;
  assign REQ_REPOR = repor_r;
  assign VAZIO     = (reg_r == 7'd0);

endmodule

// File: tb/tb_modulo_controle_rolhas.sv
// Self-checking bench for modulo_controle_rolhas.
// Directed scenarios plus a randomized phase, all compared every cycle with a
// behavioural model that tracks the count, the pending refill and the
// remaining conversion time (count/10 + 1 cycles) using plain arithmetic.
// A second instance with LIMIAR=100 exercises saturation at 99.

module tb_modulo_controle_rolhas;

  localparam int MAXR = 99;
  localparam int LIM  = 5;
  localparam int LOT  = 15;
  localparam int TMO  = 8;

  logic       clk;
  logic       rst;
  logic       start, req_vedar, repor_ok;
  logic       ack_vedar, req_repor, bcd_valid, vazio, alarme;
  logic [6:0] reg_r;
  logic [3:0] reg_rd, reg_ru;

  logic       s_rst, s_start, s_req, s_repor;
  logic       s_ack, s_req_repor, s_valid, s_vazio, s_alarme;
  logic [6:0] s_reg_r;
  logic [3:0] s_rd, s_ru;

  int n_checks = 0;
  int n_errors = 0;
  int obs_acks = 0;

  // reference model state
  int m_count, m_pend, m_busy, m_ack, m_req_repor, m_rd, m_ru, m_valid, m_wd, m_alarm;

  modulo_controle_rolhas #(.MAX_ROLHAS(MAXR), .LIMIAR(LIM), .LOTE(LOT), .TIMEOUT(TMO)) dut (
    .CLK(clk), .RESET(rst), .START(start), .REQ_VEDAR(req_vedar), .ACK_VEDAR(ack_vedar),
    .REQ_REPOR(req_repor), .REPOR_OK(repor_ok), .REG_R(reg_r), .REG_RD(reg_rd), .REG_RU(reg_ru),
    .BCD_VALID(bcd_valid), .VAZIO(vazio), .ALARME(alarme)
  );

  modulo_controle_rolhas #(.MAX_ROLHAS(MAXR), .LIMIAR(100), .LOTE(LOT), .TIMEOUT(1000)) dut_sat (
    .CLK(clk), .RESET(s_rst), .START(s_start), .REQ_VEDAR(s_req), .ACK_VEDAR(s_ack),
    .REQ_REPOR(s_req_repor), .REPOR_OK(s_repor), .REG_R(s_reg_r), .REG_RD(s_rd), .REG_RU(s_ru),
    .BCD_VALID(s_valid), .VAZIO(s_vazio), .ALARME(s_alarme)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int esp);
    n_checks++;
    if (obs != esp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, esp);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_pend = 0; m_busy = 0; m_ack = 0; m_req_repor = 0;
    m_rd = 0; m_ru = 0; m_valid = 1; m_wd = 0; m_alarm = 0;
  endtask

  // Advance the model by one rising edge given the inputs held before it.
  task automatic model_step(input logic st, input logic rq, input logic rp);
    int acc, nrr, old_rr;
    acc    = (rp && m_req_repor != 0) ? 1 : 0;
    nrr    = (m_count < LIM && m_pend == 0 && !rp) ? 1 : 0;
    old_rr = m_req_repor;
    m_ack  = 0;
    if (m_busy == 0) begin
      if (m_pend != 0) begin
        m_count = m_count + LOT;
        if (m_count > MAXR) m_count = MAXR;
        m_pend  = 0;
        m_valid = 0;
        m_busy  = m_count / 10 + 1;
      end else if (rq && st && m_count != 0 && acc == 0) begin
        m_count = m_count - 1;
        m_ack   = 1;
        m_valid = 0;
        m_busy  = m_count / 10 + 1;
      end
    end else begin
      m_busy = m_busy - 1;
      if (m_busy == 0) begin
        m_rd    = m_count / 10;
        m_ru    = m_count % 10;
        m_valid = 1;
      end
    end
    if (acc != 0) m_pend = 1;
`ifdef ROLHAS_WATCHDOG_EN
    if (old_rr != 0) begin
      m_wd = m_wd + 1;
      if (m_wd >= TMO) m_alarm = 1;
    end else begin
      m_wd = 0;
    end
`endif
    m_req_repor = nrr;
  endtask

  task automatic compare_all();
    check_val("REG_R", reg_r, m_count);
    check_val("REG_RD", reg_rd, m_rd);
    check_val("REG_RU", reg_ru, m_ru);
    check_val("BCD_VALID", bcd_valid, m_valid);
    check_val("ACK_VEDAR", ack_vedar, m_ack);
    check_val("REQ_REPOR", req_repor, m_req_repor);
    check_val("VAZIO", vazio, (m_count == 0) ? 1 : 0);
    check_val("ALARME", alarme, m_alarm);
  endtask

  // Called at a falling edge: drive, step model, cross the rising edge, compare.
  task automatic cycle(input logic st, input logic rq, input logic rp);
    start = st; req_vedar = rq; repor_ok = rp;
    model_step(st, rq, rp);
    @(posedge clk);
    @(negedge clk);
    if (ack_vedar) obs_acks++;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; req_vedar = 1'b0; repor_ok = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    compare_all();
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=0 expected=1");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int espera, n_low, guard;
    logic st, rp, rq_hold;

    rst = 1'b1; start = 1'b0; req_vedar = 1'b0; repor_ok = 1'b0;
    s_rst = 1'b1; s_start = 1'b0; s_req = 1'b0; s_repor = 1'b0;
    model_reset();

    // Saturation: seven refills from 0 on the LIMIAR=100 instance.
    repeat (2) @(posedge clk);
    @(negedge clk);
    s_rst = 1'b0;
    @(negedge clk);
    check_val("sat_req_repor_after_reset", s_req_repor, 1);
    for (int k = 0; k < 7; k++) begin
      espera = 0;
      while (!(s_req_repor && s_valid) && espera < 40) begin
        @(negedge clk);
        espera++;
      end
      if (espera >= 40) check_val("sat_wait_timeout", 0, 1);
      s_repor = 1'b1;
      @(negedge clk);
      s_repor = 1'b0;
    end
    n_low = 0;
    repeat (15) begin
      @(negedge clk);
      if (!s_valid) n_low++;
    end
    check_val("sat_conv_cycles", n_low, 10);
    check_val("sat_reg_r", s_reg_r, 99);
    check_val("sat_rd", s_rd, 9);
    check_val("sat_ru", s_ru, 9);
    check_val("sat_valid", s_valid, 1);
    check_val("sat_vazio", s_vazio, 0);
    check_val("sat_ack", s_ack, 0);
    check_val("sat_alarme", s_alarme, 0);

    // Reset state and empty stock: requests are not granted.
    do_reset();
    check_val("rst_reg_r", reg_r, 0);
    check_val("rst_bcd_valid", bcd_valid, 1);
    check_val("rst_req_repor", req_repor, 0);
    check_val("rst_vazio", vazio, 1);
    obs_acks = 0;
    repeat (4) cycle(1'b1, 1'b1, 1'b0);
    check_val("empty_no_ack", obs_acks, 0);
    check_val("empty_req_repor", req_repor, 1);

    // One refill from 0.
    cycle(1'b1, 1'b0, 1'b1);
    repeat (4) cycle(1'b1, 1'b0, 1'b0);
    check_val("refill_reg_r", reg_r, 15);
    check_val("refill_rd", reg_rd, 1);
    check_val("refill_ru", reg_ru, 5);
    check_val("refill_valid", bcd_valid, 1);
    check_val("refill_req_repor", req_repor, 0);

    // Held request drains 15 -> 4; each grant acknowledged once.
    obs_acks = 0;
    guard = 0;
    while (!(m_count == 4 && m_busy == 0) && guard < 200) begin
      cycle(1'b1, 1'b1, 1'b0);
      guard++;
    end
    if (guard >= 200) check_val("drain_timeout", 0, 1);
    check_val("drain_acks", obs_acks, 11);
    check_val("drain_reg_r", reg_r, 4);
    check_val("drain_req_repor", req_repor, 1);
    repeat (6) cycle(1'b0, 1'b1, 1'b0);
    check_val("start0_reg_r", reg_r, 4);
    check_val("start0_acks", obs_acks, 11);

    // Count 3, refill and grant in the same cycle: refill first, one ACK.
    cycle(1'b1, 1'b1, 1'b0);
    repeat (2) cycle(1'b1, 1'b0, 1'b0);
    check_val("three_reg_r", reg_r, 3);
    obs_acks = 0;
    cycle(1'b1, 1'b1, 1'b1);
    repeat (10) cycle(1'b1, (obs_acks == 0), 1'b0);
    check_val("race_acks", obs_acks, 1);
    check_val("race_reg_r", reg_r, 17);

    // Watchdog behaviour (or constant 0 without the feature).
    do_reset();
    repeat (12) cycle(1'b1, 1'b0, 1'b0);
`ifdef ROLHAS_WATCHDOG_EN
    check_val("wd_alarm_set", alarme, 1);
    cycle(1'b1, 1'b0, 1'b1);
    repeat (5) cycle(1'b1, 1'b0, 1'b0);
    check_val("wd_alarm_sticky", alarme, 1);
    do_reset();
    check_val("wd_alarm_cleared", alarme, 0);
`else
    check_val("no_wd_alarm", alarme, 0);
`endif

    // Randomized traffic with a protocol-following requester.
    do_reset();
    rq_hold = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      st = ($urandom_range(0, 7) != 0);
      rp = ($urandom_range(0, 5) == 0);
      if (rq_hold && m_ack != 0) rq_hold = 1'b0;
      else if (!rq_hold && $urandom_range(0, 2) == 0) rq_hold = 1'b1;
      cycle(st, rq_hold, rp);
      if (i % 1000 == 999) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
